matrix_row_store: RTL
=====================

Name: matrix_row_store

Overview:
- Row-organised storage serving the matrix multiply engine: the memory-side responder for the engine's A/B row-read and C row-write ports.
- Three banks A, B, C, each SIZE_COUNT rows × SIZE_COUNT elements × DATA_WIDTH.
- Engine side: addressed whole-row access.
- Host side: element-serial valid/ready streams to load A or B, and to drain C, row-major within a configured window.

Parameters:
SIZE_COUNT, 8, rows per bank and elements per row
SIZE_WIDTH, $clog2(SIZE_COUNT), row/column index width
ADDR_WIDTH, 32, engine address width
DATA_WIDTH, 16, element width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
mat_a_address  input  ADDR_WIDTH  engine A row index (low SIZE_WIDTH bits used)
mat_a_read_data  output  DATA_WIDTH×SIZE_COUNT  A row, registered
mat_b_address  input  ADDR_WIDTH  engine B row index
mat_b_read_data  output  DATA_WIDTH×SIZE_COUNT  B row, registered
mat_c_write  input  1  engine C row write strobe
mat_c_address  input  ADDR_WIDTH  engine C row index
mat_c_write_data  input  DATA_WIDTH×SIZE_COUNT  C row data
cfg_rows  input  SIZE_WIDTH  last row index of window (k means k+1 rows)
cfg_cols  input  SIZE_WIDTH  last column index of window
host_load_start  input  1  begin load; host_sel chooses the bank
host_sel  input  1  0 = A, 1 = B
host_wr_valid  input  1  element valid
host_wr_ready  output  1  element accepted
host_wr_data  input  DATA_WIDTH  element
load_done  output  1  one-cycle pulse after the last element is accepted
host_drain_start  input  1  begin C drain
host_rd_valid  output  1  drain element valid
host_rd_ready  input  1  host accepts element
host_rd_data  output  DATA_WIDTH  C element
host_rd_last  output  1  final element of window
busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, reset_n low):
  - Go to IDLE.
  - All outputs are 0.
  - Row/column counters are 0.
  - Bank contents are not reset.
- Engine address handling:
  - Address bits above SIZE_WIDTH are ignored.
  - An index ≥ SIZE_COUNT (non-power-of-2 SIZE_COUNT) reads all-zero; writes to it are dropped.
- A/B engine reads:
  - Address is sampled every cycle, in every state.
  - Data appears on the cycle after the sampling edge (1-cycle latency).
  - A read of a row being host-written in the same cycle returns the old value.
- C engine write: when mat_c_write is high, the full row is written at the edge, in any state.
- States: IDLE, LOAD, DRAIN (plus CLEAR, see Optional Feature).
- IDLE:
  - host_load_start → LOAD: capture host_sel, cfg_rows, cfg_cols; row=col=0.
  - else host_drain_start → DRAIN: capture cfg_rows, cfg_cols.
  - Both starts in the same cycle: LOAD wins, drain start is dropped.
  - Starts in any non-IDLE state are ignored.
- LOAD:
  - host_wr_ready = 1.
  - Each valid&ready handshake writes bank[sel][row][col].
  - col increments; at col == cfg_cols it wraps to 0 and row increments.
  - The handshake at (cfg_rows, cfg_cols) → IDLE, with load_done pulsing the next cycle and host_wr_ready low.
  - Elements outside the window are untouched.
- DRAIN:
  - host_rd_valid is high from the cycle after start was sampled, presenting C[row][col], starting at (0,0).
  - While valid && !ready, host_rd_data and host_rd_last hold stable.
  - Each handshake advances row-major with the same wrap rules as LOAD.
  - host_rd_last is high with element (cfg_rows, cfg_cols); its handshake → IDLE, valid drops.
  - A C write to the element currently presented does not alter held data; later elements are read after the write.
- cfg_* changes after start have no effect until the next start.

Optional Feature:
- Macro: MATRIX_STORE_ZERO_FILL_EN.
- Defined:
  - host_load_start → CLEAR for SIZE_COUNT cycles; each cycle zeroes one full row of the selected bank.
  - host_wr_ready is 0 and busy is 1 throughout CLEAR.
  - CLEAR is followed by LOAD.
  - Reset during CLEAR leaves the bank partially cleared.
- Undefined: no CLEAR state; LOAD is entered directly; stale data outside the window persists.

Test Plan:
- Load A with cfg_rows=1, cfg_cols=2, data 1..6 → load_done one cycle after the 6th handshake; mat_a_address=1 → next cycle mat_a_read_data[0..2]=4,5,6.
- mat_c_write row 0 = {10,20,…}; drain with cfg 0/1 and host_rd_ready toggling 1,0,0,1 → outputs 10 then 20, data stable during stall, host_rd_last only with 20, busy falls after the final handshake.
- host_load_start and host_drain_start in the same cycle (host_sel=1) → LOAD of B; no drain occurs; host_rd_valid stays 0.
- Reset_n low after 3 of 6 load elements → host_wr_ready=0 and busy=0 immediately; the new load restarts at (0,0), and the first 3 elements are overwritten.
- mat_b_address=0x0100_0003 → mat_b_read_data equals B row 3.
- With MATRIX_STORE_ZERO_FILL_EN: B preloaded with 0xFFFF everywhere; load cfg 0/0 data 7 → host_wr_ready low for 8 cycles, then B row 0 = {7,0,0,0,0,0,0,0} and rows 1..7 all 0.

Source files
------------

// File: rtl/matrix_row_store.sv
// matrix_row_store: A/B/C row banks with whole-row engine ports and element-serial host load/drain streams.
// MATRIX_STORE_ZERO_FILL_EN adds a CLEAR pass that zeroes the selected bank before each load.
module matrix_row_store #(
   parameter int SIZE_COUNT = 8,
   parameter int SIZE_WIDTH = $clog2(SIZE_COUNT),
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [ADDR_WIDTH-1:0]            mat_a_address,
   output logic [DATA_WIDTH*SIZE_COUNT-1:0] mat_a_read_data,
   input  logic [ADDR_WIDTH-1:0]            mat_b_address,
   output logic [DATA_WIDTH*SIZE_COUNT-1:0] mat_b_read_data,
   input  logic                             mat_c_write,
   input  logic [ADDR_WIDTH-1:0]            mat_c_address,
   input  logic [DATA_WIDTH*SIZE_COUNT-1:0] mat_c_write_data,
   input  logic [SIZE_WIDTH-1:0]            cfg_rows,
   input  logic [SIZE_WIDTH-1:0]            cfg_cols,
   input  logic                             host_load_start,
   input  logic                             host_sel,
   input  logic                             host_wr_valid,
   output logic                             host_wr_ready,
   input  logic [DATA_WIDTH-1:0]            host_wr_data,
   output logic                             load_done,
   input  logic                             host_drain_start,
   output logic                             host_rd_valid,
   input  logic                             host_rd_ready,
   output logic [DATA_WIDTH-1:0]            host_rd_data,
   output logic                             host_rd_last,
   output logic                             busy
);
   localparam int RW = DATA_WIDTH*SIZE_COUNT;
`ifdef MATRIX_STORE_ZERO_FILL_EN
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, CLEAR} state_t;
   localparam state_t ENTRY = CLEAR;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
   localparam state_t ENTRY = LOAD;
`endif
   function automatic logic in_range(input logic [SIZE_WIDTH-1:0] i);
      return 32'(i) < SIZE_COUNT;
   endfunction
   state_t state, next;
   logic [RW-1:0] mem_a [SIZE_COUNT];
   logic [RW-1:0] mem_b [SIZE_COUNT];
   logic [RW-1:0] mem_c [SIZE_COUNT];
   logic sel, wr_hs, rd_hs, at_end, wrap, c_ok, start;
   logic [SIZE_WIDTH-1:0] rows_q, cols_q, row, col, nxt_row, nxt_col, fr, fc;
   logic [SIZE_WIDTH-1:0] a_idx, b_idx, c_idx;
   logic [RW-1:0] c_row;
   logic [DATA_WIDTH-1:0] rd_data;
   logic unused_bits;
   assign a_idx = mat_a_address[SIZE_WIDTH-1:0];
   assign b_idx = mat_b_address[SIZE_WIDTH-1:0];
   assign c_idx = mat_c_address[SIZE_WIDTH-1:0];
   assign unused_bits = ^{mat_a_address[ADDR_WIDTH-1:SIZE_WIDTH], mat_b_address[ADDR_WIDTH-1:SIZE_WIDTH],
                          mat_c_address[ADDR_WIDTH-1:SIZE_WIDTH]};
   assign c_ok = mat_c_write && in_range(c_idx);
   assign start = state == IDLE && (host_load_start || host_drain_start);
   assign wr_hs = state == LOAD && host_wr_valid;
   assign rd_hs = state == DRAIN && host_rd_ready;
   assign at_end = row == rows_q && col == cols_q;
   assign wrap = col == cols_q;
   assign nxt_col = wrap ? '0 : col + 1'b1;
   assign nxt_row = wrap ? row + 1'b1 : row;
   // Next drain element, forwarding a C row written on the same edge so it is seen fresh.
   assign fr = state == DRAIN ? nxt_row : '0;
   assign fc = state == DRAIN ? nxt_col : '0;
   assign c_row = (c_ok && c_idx == fr) ? mat_c_write_data : mem_c[fr];
   assign host_wr_ready = state == LOAD;
   assign host_rd_valid = state == DRAIN;
   assign host_rd_last = host_rd_valid && at_end;
   assign host_rd_data = rd_data;
   assign busy = state != IDLE;
`ifdef MATRIX_STORE_ZERO_FILL_EN
   logic [SIZE_WIDTH-1:0] clr_cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) clr_cnt <= '0;
      else clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
   end
`endif
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = host_load_start ? ENTRY : host_drain_start ? DRAIN : IDLE;
         LOAD:    next = wr_hs && at_end ? IDLE : LOAD;
         DRAIN:   next = rd_hs && at_end ? IDLE : DRAIN;
`ifdef MATRIX_STORE_ZERO_FILL_EN
         CLEAR:   next = clr_cnt == SIZE_WIDTH'(SIZE_COUNT-1) ? LOAD : CLEAR;
`endif
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         sel <= 1'b0;
         rows_q <= '0;
         cols_q <= '0;
         row <= '0;
         col <= '0;
         load_done <= 1'b0;
         rd_data <= '0;
         mat_a_read_data <= '0;
         mat_b_read_data <= '0;
      end else begin
         state <= next;
         load_done <= wr_hs && at_end;
         mat_a_read_data <= in_range(a_idx) ? mem_a[a_idx] : '0;
         mat_b_read_data <= in_range(b_idx) ? mem_b[b_idx] : '0;
         if (start) begin
            rows_q <= cfg_rows;
            cols_q <= cfg_cols;
            row <= '0;
            col <= '0;
            if (host_load_start) sel <= host_sel;
         end
         if (wr_hs || rd_hs) begin
            row <= nxt_row;
            col <= nxt_col;
         end
         if ((start && !host_load_start) || rd_hs) rd_data <= c_row[fc*DATA_WIDTH +: DATA_WIDTH];
      end
   end
   always_ff @(posedge clk) begin
`ifdef MATRIX_STORE_ZERO_FILL_EN
      if (state == CLEAR && !sel) mem_a[clr_cnt] <= '0;
      if (state == CLEAR && sel) mem_b[clr_cnt] <= '0;
`endif
      if (wr_hs && !sel) mem_a[row][col*DATA_WIDTH +: DATA_WIDTH] <= host_wr_data;
      if (wr_hs && sel) mem_b[row][col*DATA_WIDTH +: DATA_WIDTH] <= host_wr_data;
   end
   always_ff @(posedge clk) begin
      if (c_ok) mem_c[c_idx] <= mat_c_write_data;
   end
endmodule
